// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing, parity helper.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  // State encoding, kept as named constants so the receiver can share them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } uart_state_e;

  // Parity over one data byte; odd=1 inverts the even-parity result.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic end_of_bit
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  // Free-running bit timer, parked at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign end_of_bit = !clear && (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-deep holding register for gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic StopLast = (STOP_BITS == 2);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_valid_q, hold_valid_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        end_of_bit;
  logic        consume;
  logic        accept;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == StIdle),
    .end_of_bit(end_of_bit)
  );

  // Frame sequencing; the shift register rotates so the byte is intact for parity.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    consume    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          consume = 1'b1;
          shift_d = hold_data_q;
          state_d = StStart;
        end
      end
      StStart: begin
        if (end_of_bit) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (end_of_bit) begin
          shift_d   = {shift_q[0], shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            if (PARITY_EN) begin
              state_d = StParity;
            end else begin
              state_d = StStop;
            end
          end
        end
      end
      StParity: begin
        if (end_of_bit) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (end_of_bit) begin
          if (stop_idx_q == StopLast) begin
            if (hold_valid_q) begin
              consume = 1'b1;
              shift_d = hold_data_q;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a write lands if the slot is empty or is being drained this cycle.
  always_comb begin
    accept       = wrsig && (!hold_valid_q || consume);
    overrun_d    = wrsig && !accept;
    hold_data_d  = accept ? datain : hold_data_q;
    hold_valid_d = accept || (hold_valid_q && !consume);
  end

  // Output values decoded from the next state so tx and busy come straight from flops.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_bit(shift_d, PARITY_ODD);
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || hold_valid_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: timing model predicts frame starts and overruns,
// a line monitor decodes every frame and compares against the queued expectation.
module tb_uart_tx;

  localparam int CPB     = 16;
  localparam int FRAME   = CPB * 10;
  localparam int FRAME_P = CPB * 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datain;
  logic       wrsig;
  logic       wr_p;
  logic       tx, busy, overrun;
  logic       tx_pe, busy_pe, ovr_pe;
  logic       tx_po, busy_po, ovr_po;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int frames_seen = 0;
  int prev_start = 0;
  int last_start = 0;
  bit mon_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int     ovr_q[$];

  // Reference timing model state.
  int m_frame_end;
  int m_hc;
  bit m_has_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx u_dut (
    .clk(clk), .rst(rst), .datain(datain), .wrsig(wrsig),
    .tx(tx), .busy(busy), .overrun(overrun)
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par_even (
    .clk(clk), .rst(rst), .datain(datain), .wrsig(wr_p),
    .tx(tx_pe), .busy(busy_pe), .overrun(ovr_pe)
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_par_odd (
    .clk(clk), .rst(rst), .datain(datain), .wrsig(wr_p),
    .tx(tx_po), .busy(busy_po), .overrun(ovr_po)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level for bit slot 'slot' of a frame carrying 'd'.
  function automatic logic frame_bit(input logic [7:0] d, input int slot, input bit pen,
                                     input bit odd);
    logic p;
    p = (($countones(d) % 2) != 0) ^ odd;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (pen && slot == 9) return p;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_has_hold  = 1'b0;
    m_frame_end = -100000;
    m_hc        = 0;
    exp_q.delete();
    ovr_q.delete();
  endtask

  // A write at cycle t: the held byte leaves at m_hc and starts its frame one cycle later.
  task automatic model_write(input int t, input logic [7:0] b);
    frame_t f;
    if (m_has_hold && m_hc <= t) begin
      m_frame_end = m_hc + FRAME;
      m_has_hold  = 1'b0;
    end
    if (m_has_hold) begin
      ovr_q.push_back(t + 1);
    end else begin
      m_hc       = (m_frame_end >= t + 1) ? m_frame_end : t + 1;
      m_has_hold = 1'b1;
      f.data     = b;
      f.start    = m_hc + 1;
      exp_q.push_back(f);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wrsig  = 1'b1;
    datain = b;
    model_write(cyc, b);
    tick(1);
    wrsig = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0 || mon_busy) && k < 4000) begin
      tick(1);
      k++;
    end
    check({name, "_drain_in_bound"}, int'(k < 4000), 1);
    tick(4);
  endtask

  // Line monitor: decode each frame cycle by cycle against the popped expectation.
  initial begin : frame_mon
    frame_t     e;
    bit         have;
    bit         aborted;
    int         s;
    int         bad;
    logic [7:0] dec;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        mon_busy = 1'b1;
        s        = cyc;
        bad      = 0;
        aborted  = 1'b0;
        dec      = '0;
        have     = (exp_q.size() != 0);
        if (have) begin
          e = exp_q.pop_front();
        end else begin
          e.data  = '0;
          e.start = -1;
        end
        check("frame_expected", int'(have), 1);
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (rst !== 1'b0) aborted = 1'b1;
          if (!aborted) begin
            if (tx !== frame_bit(e.data, k / CPB, 1'b0, 1'b0)) bad++;
            if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) dec[k/CPB-1] = tx;
          end
        end
        if (!aborted && have) begin
          check("frame_start_cycle", s, e.start);
          check("frame_waveform_bad_cycles", bad, 0);
          check("frame_decoded_byte", int'(dec), int'(e.data));
          prev_start = last_start;
          last_start = s;
          frames_seen++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Overrun monitor: every pulse must match a predicted drop cycle.
  initial begin : ovr_mon
    int e;
    forever begin
      @(negedge clk);
      if (overrun === 1'b1) begin
        e = (ovr_q.size() != 0) ? ovr_q.pop_front() : -1;
        check("overrun_pulse_cycle", cyc, e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int n0;
    int bad_e;
    int bad_o;
    int seen0;
    int gap;

    rst    = 1'b1;
    datain = '0;
    wrsig  = 1'b0;
    wr_p   = 1'b0;
    model_reset();
    tick(3);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(5);

    // Single byte: busy timing around a lone frame.
    n0 = cyc;
    write_byte(8'h55);
    check("single_busy_n1", int'(busy), 1);
    check("single_tx_n1", int'(tx), 1);
    tick(160);
    check("single_cycle_n161", cyc - n0, 161);
    check("single_busy_n161", int'(busy), 1);
    tick(1);
    check("single_busy_n162", int'(busy), 0);
    wait_idle("single");

    // Parity variants on the two parity-enabled instances.
    datain = 8'h07;
    wr_p   = 1'b1;
    tick(1);
    wr_p = 1'b0;
    tick(1);
    bad_e = 0;
    bad_o = 0;
    for (int k = 0; k < FRAME_P; k++) begin
      if (tx_pe !== frame_bit(8'h07, k / CPB, 1'b1, 1'b0)) bad_e++;
      if (tx_po !== frame_bit(8'h07, k / CPB, 1'b1, 1'b1)) bad_o++;
      if (k == 9 * CPB + CPB / 2) begin
        check("parity_even_bit", int'(tx_pe), 1);
        check("parity_odd_bit", int'(tx_po), 0);
      end
      if (k == FRAME_P - 1) check("parity_busy_last_cycle", int'(busy_pe), 1);
      tick(1);
    end
    check("parity_even_waveform_bad_cycles", bad_e, 0);
    check("parity_odd_waveform_bad_cycles", bad_o, 0);
    check("parity_busy_after_176", int'(busy_pe), 0);
    tick(4);

    // Back-to-back: second write lands in the hold register mid-frame.
    write_byte(8'hA0);
    tick(19);
    write_byte(8'h0F);
    wait_idle("b2b");
    check("b2b_start_gap", last_start - prev_start, FRAME);

    // Overrun: three strobes on consecutive cycles while idle.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_idle("overrun");

    // Reset during data bit 3, then a clean frame.
    n0 = cyc;
    write_byte(8'hA5);
    tick(70);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    check("midreset_tx", int'(tx), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_overrun", int'(overrun), 0);
    tick(200);
    write_byte(8'hC3);
    wait_idle("reset_recover");

    // Upstream soak: one strobe every 1017 cycles, incrementing through the FF->00 wrap.
    seen0 = frames_seen;
    for (int i = 0; i < 32; i++) begin
      write_byte(8'hE8 + 8'(i));
      tick(1016);
    end
    wait_idle("soak");
    check("soak_frames_decoded", frames_seen - seen0, 32);

    // Random bytes with random gaps, including bursts that overrun.
    for (int i = 0; i < 60; i++) begin
      write_byte(8'($urandom));
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 250));
      tick(gap);
    end
    wait_idle("random");

    tick(10);
    check("frames_left_unsent", exp_q.size(), 0);
    check("overruns_left_unseen", ovr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
